// File: rtl/quiz_round_controller.sv
// quiz_round_controller
// Round sequencer for a 4-player responder. It clears and enables the responder,
// runs the answer countdown, applies the host's judgement to per-player scores,
// and drives the timeout beep. All outputs come from registers.
module quiz_round_controller #(
    parameter int TICK_DIV    = 50_000_000,
    parameter int ANSWER_SECS = 30,
    parameter int BEEP_CYC    = 25_000_000,
    parameter int SCORE_W     = 4
) (
    input  logic                 CLK,
    input  logic                 Rst,
    input  logic                 Host_Start,
    input  logic                 Host_Correct,
    input  logic                 Host_Wrong,
    input  logic                 Timer_Start,
    input  logic [3:0]           Player_Number,
    output logic                 Resp_Rstn,
    output logic                 Resp_Start,
    output logic [6:0]           Countdown,
    output logic                 Timeout_Beep,
    output logic [2:0]           Round_State,
    output logic [4*SCORE_W-1:0] Scores
);

    localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int BEEP_W = (BEEP_CYC > 1) ? $clog2(BEEP_CYC) : 1;
    localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        ARMED   = 3'd2,
        ANSWER  = 3'd3,
        TIMEOUT = 3'd4,
        DONE    = 3'd5
    } round_state_t;

    round_state_t        state;
    round_state_t        next_state;
    logic [2:0]          start_sync;
    logic [2:0]          correct_sync;
    logic [2:0]          wrong_sync;
    logic [DIV_W-1:0]    tick_cnt;
    logic [BEEP_W-1:0]   beep_cnt;
    logic [SCORE_W-1:0]  score_q [4];
    logic                start_ev;
    logic                correct_ev;
    logic                wrong_ev;
    logic                judge_ev;
    logic                tick;
    logic                final_tick;
    logic                beep_end;
    logic                player_valid;
    logic [1:0]          player_idx;

    // Host keys idle high; each passes two synchronizing flops plus one history flop for edge detection
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            start_sync   <= 3'b111;
            correct_sync <= 3'b111;
            wrong_sync   <= 3'b111;
        end else begin
            start_sync   <= {start_sync[1:0], Host_Start};
            correct_sync <= {correct_sync[1:0], Host_Correct};
            wrong_sync   <= {wrong_sync[1:0], Host_Wrong};
        end
    end

    assign start_ev     = start_sync[2] & ~start_sync[1];
    assign correct_ev   = correct_sync[2] & ~correct_sync[1];
    assign wrong_ev     = wrong_sync[2] & ~wrong_sync[1];
    assign judge_ev     = correct_ev ^ wrong_ev;
    assign tick         = (state == ARMED) && (tick_cnt == DIV_W'(TICK_DIV - 1));
    assign final_tick   = tick && (Countdown == 7'd1);
    assign beep_end     = (beep_cnt == BEEP_W'(BEEP_CYC - 1));
    assign player_valid = (Player_Number >= 4'd1) && (Player_Number <= 4'd4);
    assign player_idx   = 2'(Player_Number - 4'd1);

    // Round sequencing; a player press beats a simultaneous final tick
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ev) next_state = CLEAR;
            CLEAR:   next_state = ARMED;
            ARMED: begin
                if (Timer_Start)     next_state = ANSWER;
                else if (final_tick) next_state = TIMEOUT;
            end
            ANSWER:  if (judge_ev) next_state = DONE;
            TIMEOUT: if (beep_end) next_state = DONE;
            DONE:    if (start_ev) next_state = CLEAR;
            default: next_state = IDLE;
        endcase
    end

    // State register with responder controls and beep registered from the upcoming state
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            state        <= IDLE;
            Resp_Rstn    <= 1'b0;
            Resp_Start   <= 1'b0;
            Timeout_Beep <= 1'b0;
        end else begin
            state        <= next_state;
            Resp_Rstn    <= (next_state != IDLE) && (next_state != CLEAR);
            Resp_Start   <= (next_state == ARMED) || (next_state == ANSWER);
            Timeout_Beep <= (next_state == TIMEOUT);
        end
    end

    assign Round_State = state;

    // Seconds divider and countdown; a press freezes the count in the cycle it arrives
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            Countdown <= 7'(ANSWER_SECS);
            tick_cnt  <= '0;
        end else if (state == CLEAR) begin
            Countdown <= 7'(ANSWER_SECS);
            tick_cnt  <= '0;
        end else if (state == ARMED) begin
            if (tick) begin
                tick_cnt <= '0;
                if (!Timer_Start) Countdown <= Countdown - 7'd1;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Beep length counter, only runs while the timeout state is held
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst)                   beep_cnt <= '0;
        else if (state == TIMEOUT) beep_cnt <= beep_cnt + 1'b1;
        else                       beep_cnt <= '0;
    end

    // Saturating score update on a single judge event for a valid winner
    always_ff @(posedge CLK or posedge Rst) begin
        if (Rst) begin
            for (int i = 0; i < 4; i++) score_q[i] <= '0;
        end else if ((state == ANSWER) && judge_ev && player_valid) begin
            if (correct_ev && (score_q[player_idx] != SCORE_MAX))
                score_q[player_idx] <= score_q[player_idx] + 1'b1;
            else if (wrong_ev && (score_q[player_idx] != '0))
                score_q[player_idx] <= score_q[player_idx] - 1'b1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_pack
        assign Scores[g*SCORE_W +: SCORE_W] = score_q[g];
    end

endmodule

// File: tb/tb_quiz_round_controller.sv
// tb_quiz_round_controller
// Directed rounds against a scoreboard: expected state transitions, countdown
// steps and beep lengths are queued up front and popped by a monitor.
module tb_quiz_round_controller;

    logic        CLK;
    logic        Rst;
    logic        Host_Start;
    logic        Host_Correct;
    logic        Host_Wrong;
    logic        Timer_Start;
    logic [3:0]  Player_Number;
    logic        Resp_Rstn;
    logic        Resp_Start;
    logic [6:0]  Countdown;
    logic        Timeout_Beep;
    logic [2:0]  Round_State;
    logic [15:0] Scores;

    typedef struct {
        logic [2:0]  st;
        logic [6:0]  cd;
        logic [15:0] sc;
        logic [2:0]  ctrl;
        logic [2:0]  mask;
        int          dwell;
    } st_rec_t;

    typedef struct {
        logic [6:0] val;
        int         gap;
    } cd_rec_t;

    st_rec_t st_q[$];
    cd_rec_t cd_q[$];
    int      beep_q[$];

    int check_count = 0;
    int pass_count  = 0;

    logic [2:0] last_st;
    logic [6:0] last_cd;
    logic       last_beep;
    int         st_cnt;
    int         cd_cnt;
    int         beep_len;
    st_rec_t    srec;
    cd_rec_t    crec;
    int         brec;

    quiz_round_controller #(
        .TICK_DIV(4),
        .ANSWER_SECS(3),
        .BEEP_CYC(5),
        .SCORE_W(4)
    ) dut (
        .CLK(CLK),
        .Rst(Rst),
        .Host_Start(Host_Start),
        .Host_Correct(Host_Correct),
        .Host_Wrong(Host_Wrong),
        .Timer_Start(Timer_Start),
        .Player_Number(Player_Number),
        .Resp_Rstn(Resp_Rstn),
        .Resp_Start(Resp_Start),
        .Countdown(Countdown),
        .Timeout_Beep(Timeout_Beep),
        .Round_State(Round_State),
        .Scores(Scores)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic reportExtra(input string name, input logic [31:0] act);
        check_count++;
        $display("[TB] FAIL %s: got 0x%0h, expected no further event", name, act);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #2;
    endtask

    task automatic applyStimulus(input logic hs, input logic hc, input logic hw,
                                 input logic ts, input logic [3:0] pn);
        Host_Start    = hs;
        Host_Correct  = hc;
        Host_Wrong    = hw;
        Timer_Start   = ts;
        Player_Number = pn;
    endtask

    // Hold the given keys low for four cycles; the controller acts on the third edge
    task automatic pressKeys(input logic hs, input logic hc, input logic hw);
        applyStimulus(hs, hc, hw, Timer_Start, Player_Number);
        cyc(4);
        applyStimulus(1'b1, 1'b1, 1'b1, Timer_Start, Player_Number);
    endtask

    task automatic pushState(input logic [2:0] st, input logic [6:0] cd, input logic [15:0] sc,
                             input logic [2:0] ctrl, input logic [2:0] mask, input int dwell);
        st_rec_t r;
        r.st = st; r.cd = cd; r.sc = sc; r.ctrl = ctrl; r.mask = mask; r.dwell = dwell;
        st_q.push_back(r);
    endtask

    task automatic pushCd(input logic [6:0] val, input int gap);
        cd_rec_t r;
        r.val = val; r.gap = gap;
        cd_q.push_back(r);
    endtask

    // Monitor: compares every state change, countdown change and finished beep against the queues
    always @(negedge CLK) begin
        if (Rst) begin
            last_st   = Round_State;
            last_cd   = Countdown;
            last_beep = Timeout_Beep;
            st_cnt    = 0;
            cd_cnt    = 0;
            beep_len  = 0;
        end else begin
            if (Round_State !== last_st) begin
                if (st_q.size() == 0) reportExtra("state_extra", 32'(Round_State));
                else begin
                    srec = st_q.pop_front();
                    checkOutput($sformatf("state_to_%0d", srec.st), 32'(Round_State), 32'(srec.st));
                    checkOutput($sformatf("state_%0d_countdown", srec.st), 32'(Countdown), 32'(srec.cd));
                    checkOutput($sformatf("state_%0d_scores", srec.st), 32'(Scores), 32'(srec.sc));
                    checkOutput($sformatf("state_%0d_ctrl", srec.st),
                                32'({Resp_Rstn, Resp_Start, Timeout_Beep} & srec.mask),
                                32'(srec.ctrl & srec.mask));
                    if (srec.dwell >= 0)
                        checkOutput($sformatf("state_%0d_prev_dwell", srec.st), 32'(st_cnt), 32'(srec.dwell));
                end
                st_cnt = 1;
            end else st_cnt++;

            if (Countdown !== last_cd) begin
                if (cd_q.size() == 0) reportExtra("countdown_extra", 32'(Countdown));
                else begin
                    crec = cd_q.pop_front();
                    checkOutput("countdown_value", 32'(Countdown), 32'(crec.val));
                    if (crec.gap >= 0)
                        checkOutput("countdown_step_gap", 32'(cd_cnt), 32'(crec.gap));
                end
                cd_cnt = 1;
            end else cd_cnt++;

            if (Timeout_Beep) beep_len++;
            else if (last_beep) begin
                if (beep_q.size() == 0) reportExtra("beep_extra", 32'(beep_len));
                else begin
                    brec = beep_q.pop_front();
                    checkOutput("beep_length", 32'(beep_len), 32'(brec));
                end
                beep_len = 0;
            end

            last_st   = Round_State;
            last_cd   = Countdown;
            last_beep = Timeout_Beep;
        end
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed rounds
    initial begin
        logic [15:0] prev_sc;
        logic [15:0] new_sc;
        Rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        #1 Rst = 1'b1;
        #1;
        checkOutput("reset_state", 32'(Round_State), 32'd0);
        checkOutput("reset_resp_rstn", 32'(Resp_Rstn), 32'd0);
        checkOutput("reset_resp_start", 32'(Resp_Start), 32'd0);
        checkOutput("reset_countdown", 32'(Countdown), 32'd3);
        checkOutput("reset_scores", 32'(Scores), 32'd0);
        cyc(3);
        Rst = 1'b0;
        cyc(3);
        checkOutput("idle_holds_state", 32'(Round_State), 32'd0);
        checkOutput("idle_resp_start", 32'(Resp_Start), 32'd0);

        $display("[TB] round 1: player 2 answers correctly");
        pushState(3'd1, 7'd3, 16'h0000, 3'b000, 3'b111, -1);
        pushState(3'd2, 7'd3, 16'h0000, 3'b110, 3'b111, 1);
        pushState(3'd3, 7'd2, 16'h0000, 3'b110, 3'b111, 6);
        pushState(3'd5, 7'd2, 16'h0010, 3'b100, 3'b111, 4);
        pushCd(7'd2, -1);
        pressKeys(1'b0, 1'b1, 1'b1);
        cyc(5);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
        cyc(2);
        pressKeys(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);

        $display("[TB] round 2: nobody presses, timeout");
        pushState(3'd1, 7'd2, 16'h0010, 3'b000, 3'b111, -1);
        pushState(3'd2, 7'd3, 16'h0010, 3'b110, 3'b111, 1);
        pushState(3'd4, 7'd0, 16'h0010, 3'b001, 3'b001, 12);
        pushState(3'd5, 7'd0, 16'h0010, 3'b100, 3'b111, 5);
        pushCd(7'd3, -1);
        pushCd(7'd2, 4);
        pushCd(7'd1, 4);
        pushCd(7'd0, 4);
        beep_q.push_back(5);
        pressKeys(1'b0, 1'b1, 1'b1);
        cyc(20);

        $display("[TB] round 3: press on the final tick, then wrong on player 1");
        pushState(3'd1, 7'd0, 16'h0010, 3'b000, 3'b111, -1);
        pushState(3'd2, 7'd3, 16'h0010, 3'b110, 3'b111, 1);
        pushState(3'd3, 7'd1, 16'h0010, 3'b110, 3'b111, 12);
        pushState(3'd5, 7'd1, 16'h0010, 3'b100, 3'b111, 3);
        pushCd(7'd3, -1);
        pushCd(7'd2, 4);
        pushCd(7'd1, 4);
        pressKeys(1'b0, 1'b1, 1'b1);
        cyc(11);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd1);
        cyc(1);
        pressKeys(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        cyc(2);

        $display("[TB] rounds 4-19: player 3 correct sixteen times");
        for (int i = 0; i < 16; i++) begin
            prev_sc = 16'h0010 | (16'((i > 15) ? 15 : i) << 8);
            new_sc  = 16'h0010 | (16'((i + 1 > 15) ? 15 : i + 1) << 8);
            pushState(3'd1, (i == 0) ? 7'd1 : 7'd3, prev_sc, 3'b000, 3'b111, -1);
            pushState(3'd2, 7'd3, prev_sc, 3'b110, 3'b111, 1);
            pushState(3'd3, 7'd3, prev_sc, 3'b110, 3'b111, 1);
            pushState(3'd5, 7'd3, new_sc, 3'b100, 3'b111, 3);
            if (i == 0) pushCd(7'd3, -1);
            pressKeys(1'b0, 1'b1, 1'b1);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
            cyc(1);
            pressKeys(1'b1, 1'b0, 1'b1);
            applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
            cyc(1);
        end

        $display("[TB] round 20: simultaneous judge and start in answer are ignored");
        pushState(3'd1, 7'd3, 16'h0F10, 3'b000, 3'b111, -1);
        pushState(3'd2, 7'd3, 16'h0F10, 3'b110, 3'b111, 1);
        pushState(3'd3, 7'd3, 16'h0F10, 3'b110, 3'b111, 1);
        pushState(3'd5, 7'd3, 16'h0F20, 3'b100, 3'b111, 13);
        pressKeys(1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd2);
        cyc(1);
        pressKeys(1'b1, 1'b0, 1'b0);
        cyc(1);
        pressKeys(1'b0, 1'b1, 1'b1);
        cyc(1);
        pressKeys(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
        cyc(1);

        $display("[TB] round 21: reset during the beep");
        pushState(3'd1, 7'd3, 16'h0F20, 3'b000, 3'b111, -1);
        pushState(3'd2, 7'd3, 16'h0F20, 3'b110, 3'b111, 1);
        pushState(3'd4, 7'd0, 16'h0F20, 3'b001, 3'b001, 12);
        pushCd(7'd2, -1);
        pushCd(7'd1, 4);
        pushCd(7'd0, 4);
        pressKeys(1'b0, 1'b1, 1'b1);
        cyc(14);
        checkOutput("beep_before_reset", 32'(Timeout_Beep), 32'd1);
        Rst = 1'b1;
        #1;
        checkOutput("midbeep_reset_beep", 32'(Timeout_Beep), 32'd0);
        checkOutput("midbeep_reset_state", 32'(Round_State), 32'd0);
        checkOutput("midbeep_reset_scores", 32'(Scores), 32'd0);
        checkOutput("midbeep_reset_countdown", 32'(Countdown), 32'd3);
        checkOutput("midbeep_reset_resp_rstn", 32'(Resp_Rstn), 32'd0);
        cyc(2);
        Rst = 1'b0;
        cyc(3);

        checkOutput("state_queue_drained", 32'(st_q.size()), 32'd0);
        checkOutput("countdown_queue_drained", 32'(cd_q.size()), 32'd0);
        checkOutput("beep_queue_drained", 32'(beep_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
